// File: rtl/serial_add_pkg.sv
// Shared constants for the word-serial adder/subtractor: word width,
// default operand size and the controller state encoding.
package serial_add_pkg;

  localparam int unsigned WORD_W         = 16;
  localparam int unsigned NWORDS_DEFAULT = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_e;

endpackage

// File: rtl/rca_16bits.sv
// 16-bit ripple-carry adder; the single arithmetic resource shared by every
// word of a serial operation.
module rca_16bits
  import serial_add_pkg::*;
(
  input  logic [WORD_W-1:0] in1,
  input  logic [WORD_W-1:0] in2,
  input  logic              cin,
  output logic [WORD_W-1:0] out,
  output logic              cout
);

  always_comb begin
    logic c;
    c   = cin;
    out = '0;
    for (int unsigned i = 0; i < WORD_W; i++) begin
      out[i] = in1[i] ^ in2[i] ^ c;
      c      = (in1[i] & in2[i]) | (c & (in1[i] ^ in2[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// Word-serial add/subtract controller: one 16-bit word per cycle through a
// shared ripple-carry adder, carry chained through a register between words.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned NWORDS = NWORDS_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     op_sub,
  input  logic [WORD_W*NWORDS-1:0] a,
  input  logic [WORD_W*NWORDS-1:0] b,
  input  logic                     cin,
  output logic                     busy,
  output logic                     done,
  output logic [WORD_W*NWORDS-1:0] sum,
  output logic                     cout,
  output logic                     ovf
);

  localparam int unsigned   DW       = WORD_W * NWORDS;
  localparam int unsigned   IW       = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NWORDS - 1);

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [DW-1:0]   a_q, a_d;
  logic [DW-1:0]   b_q, b_d;
  logic [DW-1:0]   res_q, res_d;
  logic [DW-1:0]   sum_q, sum_d;
  logic            sub_q, sub_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;
  logic            armed_q;

  logic [WORD_W-1:0] word_a, word_b, word_s;
  logic              word_c;
  logic              accept;
  logic              b_msb_eff;

  // armed_q stays low for the first edge after reset release so a start held
  // across the release is not taken on that edge.
  assign accept = start && armed_q && (state_q != RUN);

  // b is kept as presented; the subtract inversion is applied on the way into
  // the adder, which is equivalent to storing ~b.
  assign word_a    = a_q[idx_q*WORD_W +: WORD_W];
  assign word_b    = b_q[idx_q*WORD_W +: WORD_W] ^ {WORD_W{sub_q}};
  assign b_msb_eff = b_q[DW-1] ^ sub_q;

  rca_16bits u_rca (
    .in1  (word_a),
    .in2  (word_b),
    .cin  (carry_q),
    .out  (word_s),
    .cout (word_c)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    sub_d   = sub_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          a_d     = a;
          b_d     = b;
          sub_d   = op_sub;
          carry_d = op_sub ? 1'b1 : cin;
          idx_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        res_d[idx_q*WORD_W +: WORD_W] = word_s;
        carry_d                       = word_c;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = DONE;
          sum_d   = res_d;
          cout_d  = word_c;
          ovf_d   = (a_q[DW-1] == b_msb_eff) && (res_d[DW-1] != a_q[DW-1]);
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      sub_q   <= sub_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      armed_q <= 1'b1;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl (NWORDS=4): directed vectors push
// expected results; a monitor pops and compares on every done pulse.
module tb_serial_add_ctrl;

  localparam int unsigned NW = 4;
  localparam int unsigned DW = 16 * NW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          op_sub;
  logic [DW-1:0] a, b;
  logic          cin;
  logic          busy, done, cout, ovf;
  logic [DW-1:0] sum;

  typedef struct {
    logic [DW-1:0] sum;
    logic          cout;
    logic          ovf;
    int unsigned   cyc;
    string         tag;
  } exp_t;

  exp_t        sbq[$];
  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned cyc   = 0;

  logic [DW-1:0] hold_sum  = '0;
  logic          hold_cout = 1'b0;
  logic          hold_ovf  = 1'b0;

  serial_add_ctrl #(.NWORDS(NW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op_sub (op_sub),
    .a      (a),
    .b      (b),
    .cin    (cin),
    .busy   (busy),
    .done   (done),
    .sum    (sum),
    .cout   (cout),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: results must appear only on done, in order, on time; outputs
  // must hold their last completed value while an operation runs.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_sum  = '0;
        hold_cout = 1'b0;
        hold_ovf  = 1'b0;
      end else if (busy) begin
        check("hold_sum", sum, hold_sum);
        check("hold_cout", cout, hold_cout);
        check("hold_ovf", ovf, hold_ovf);
      end else if (done) begin
        if (sbq.size() == 0) begin
          check("unexpected_done", done, 1'b0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check({e.tag, "_sum"}, sum, e.sum);
          check({e.tag, "_cout"}, cout, e.cout);
          check({e.tag, "_ovf"}, ovf, e.ovf);
          check({e.tag, "_lat"}, cyc, e.cyc);
          hold_sum  = e.sum;
          hold_cout = e.cout;
          hold_ovf  = e.ovf;
        end
      end
    end
  end

  task automatic push_exp(input string tag, input logic [DW-1:0] es, input logic ec, input logic eo);
    exp_t e;
    e.sum  = es;
    e.cout = ec;
    e.ovf  = eo;
    e.cyc  = cyc + NW;
    e.tag  = tag;
    sbq.push_back(e);
  endtask

  task automatic issue(input string tag, input logic [DW-1:0] ta, input logic [DW-1:0] tb_,
                       input logic tcin, input logic tsub,
                       input logic [DW-1:0] es, input logic ec, input logic eo);
    @(negedge clk);
    a = ta; b = tb_; cin = tcin; op_sub = tsub; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check({tag, "_busy"}, busy, 1'b1);
    push_exp(tag, es, ec, eo);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && sbq.size() != 0; i++) @(negedge clk);
    if (sbq.size() != 0) begin
      check("drain_timeout", sbq.size(), 0);
      sbq.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; op_sub = 1'b0; a = '0; b = '0; cin = 1'b0;
    #3;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_sum", sum, '0);
    check("rst_cout", cout, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    #17 rst_n = 1'b1;
    @(negedge clk);

    issue("add_basic", 64'd1117, 64'd232, 1'b0, 1'b0, 64'd1349, 1'b0, 1'b0);
    wait_drain();
    issue("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0);
    wait_drain();
    issue("sub_neg", 64'd10, 64'd12, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    wait_drain();
    issue("sub_pos", 64'd12, 64'd10, 1'b0, 1'b1, 64'd2, 1'b1, 1'b0);
    wait_drain();
    issue("ovf_add", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    wait_drain();
    issue("add_cin", 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b1, 1'b0,
          64'h1234_5678_9ABC_DF01, 1'b0, 1'b0);
    wait_drain();
    issue("sub_cin_ign", 64'd5, 64'd5, 1'b1, 1'b1, 64'd0, 1'b1, 1'b0);
    wait_drain();

    // Word carry, start ignored while busy, back-to-back start in DONE.
    issue("wcarry", 64'hFFFF, 64'd1, 1'b0, 1'b0, 64'h1_0000, 1'b0, 1'b0);
    @(negedge clk);
    a = 64'hAAAA; b = 64'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
        @(negedge clk);
        seen = done;
      end
      check("wcarry_done_seen", seen, 1'b1);
    end
    a = 64'd5; b = 64'd7; cin = 1'b1; op_sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("b2b_busy", busy, 1'b1);
    push_exp("b2b", 64'd13, 1'b0, 1'b0);
    wait_drain();

    issue("sub_ovf", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    wait_drain();

    // Reset at index 2 of an operation that must never complete.
    @(negedge clk);
    a = 64'h1234; b = 64'h1; cin = 1'b0; op_sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("pre_rst_sum", sum, 64'h7FFF_FFFF_FFFF_FFFF);
    rst_n = 1'b0;
    #1;
    check("arst_sum", sum, '0);
    check("arst_cout", cout, 1'b0);
    check("arst_ovf", ovf, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    repeat (3) @(negedge clk);

    // Start held across release is ignored on the first edge.
    a = 64'd100; b = 64'd23; cin = 1'b0; op_sub = 1'b0; start = 1'b1;
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("first_edge_ignored", busy, 1'b0);
    @(posedge clk);
    #1 start = 1'b0;
    check("post_rst_busy", busy, 1'b1);
    push_exp("post_rst", 64'd123, 1'b0, 1'b0);
    wait_drain();
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
